// File: rtl/ahb2apb_bridge_pkg.sv
// ahb2apb_bridge_pkg: shared AHB encodings, FSM states and default sizing for the bridge
package ahb2apb_bridge_pkg;
  localparam int SLV_NUM_DEF = 8;
  localparam int SEL_LSB_DEF = 12;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ = 2'b11;
  localparam logic HRESP_OKAY = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2} state_e;
endpackage

// File: rtl/ahb2apb_bridge_if.sv
// ahb2apb_bridge_if: AHB-Lite slave side plus APB master side of the bridge
// slave modport = bridge view (AHB in, APB out, prdata/pready in); master modport = system view
interface ahb2apb_bridge_if
  import ahb2apb_bridge_pkg::*;
#(
  parameter int SLV_NUM = SLV_NUM_DEF
);
  logic hsel;
  logic [31:0] haddr;
  logic [1:0] htrans;
  logic hwrite;
  logic [2:0] hsize;
  logic [31:0] hwdata;
  logic hready;
  logic hreadyout;
  logic hresp;
  logic [31:0] hrdata;
  logic [SLV_NUM-1:0] psel;
  logic penable;
  logic [31:0] paddr;
  logic pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic pready;
  modport slave (
    input hsel, haddr, htrans, hwrite, hsize, hwdata, hready, prdata, pready,
    output hreadyout, hresp, hrdata, psel, penable, paddr, pwrite, pwdata
  );
  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready, prdata, pready,
    input hreadyout, hresp, hrdata, psel, penable, paddr, pwrite, pwdata
  );
endinterface

// File: rtl/ahb2apb_bridge_sel_decode.sv
// ahb2apb_bridge_sel_decode: 3-bit slave index to one-hot PSEL plus out-of-range flag
// Ports: idx_i slave index, en_i decode enable, psel_o one-hot select, err_o idx_i >= SLV_NUM
module ahb2apb_bridge_sel_decode #(
  parameter int SLV_NUM = 8
) (
  input  logic [2:0]         idx_i,
  input  logic               en_i,
  output logic [SLV_NUM-1:0] psel_o,
  output logic               err_o
);
  assign err_o = 32'(idx_i) >= 32'(SLV_NUM);
  always_comb begin
    psel_o = '0;
    for (int i = 0; i < SLV_NUM; i++) psel_o[i] = en_i && idx_i == i[2:0];
  end
endmodule

// File: rtl/ahb2apb_bridge.sv
// ahb2apb_bridge: AHB-Lite slave to APB master bridge with one outstanding transfer
// Ports: hclk_i shared AHB/APB clock, hresetn_i async active-low reset, bus AHB slave + APB master (slave modport)
module ahb2apb_bridge
  import ahb2apb_bridge_pkg::*;
#(
  parameter int SLV_NUM = SLV_NUM_DEF,
  parameter int SEL_LSB = SEL_LSB_DEF
) (
  input logic             hclk_i,
  input logic             hresetn_i,
  ahb2apb_bridge_if.slave bus
);
  state_e state_q, state_d;
  logic [31:0] paddr_q, paddr_d, pwdata_q, pwdata_d, hrdata_q, hrdata_d;
  logic pwrite_q, pwrite_d;
  logic [SLV_NUM-1:0] sel_q, sel_d, dec_sel;
  logic accept, dec_err, unused_ok;
  assign accept = bus.hsel && bus.hready && bus.htrans[1];
  assign unused_ok = ^{bus.hsize, bus.htrans[0]};
  ahb2apb_bridge_sel_decode #(.SLV_NUM(SLV_NUM)) u_dec (
    .idx_i (bus.haddr[SEL_LSB+:3]),
    .en_i  (accept),
    .psel_o(dec_sel),
    .err_o (dec_err)
  );
  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) begin
      state_q  <= S_IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      hrdata_q <= '0;
      pwrite_q <= 1'b0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
      pwrite_q <= pwrite_d;
      sel_q    <= sel_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    pwrite_d = pwrite_q;
    sel_d    = sel_q;
    case (state_q)
      S_WDATA: begin
        pwdata_d = bus.hwdata;
        state_d  = S_SETUP;
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: if (bus.pready) begin
        hrdata_d = pwrite_q ? hrdata_q : bus.prdata;
        state_d  = S_DONE;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        // IDLE, DONE and ERR2 all end with HREADYOUT high, so each can take the next address phase
        state_d = S_IDLE;
        if (accept) begin
          paddr_d  = bus.haddr;
          pwrite_d = bus.hwrite;
          sel_d    = dec_sel;
          state_d  = dec_err ? S_ERR1 : bus.hwrite ? S_WDATA : S_SETUP;
        end
      end
    endcase
  end
  assign bus.psel      = (state_q == S_SETUP || state_q == S_ACCESS) ? sel_q : '0;
  assign bus.penable   = state_q == S_ACCESS;
  assign bus.paddr     = paddr_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.hrdata    = hrdata_q;
  assign bus.hreadyout = !(state_q == S_WDATA || state_q == S_SETUP || state_q == S_ACCESS || state_q == S_ERR1);
  assign bus.hresp     = (state_q == S_ERR1 || state_q == S_ERR2) ? HRESP_ERROR : HRESP_OKAY;
endmodule

// File: tb/tb_ahb2apb_bridge.sv
// tb_ahb2apb_bridge: scoreboard bench for the bridge (8-slave DUT checked per transfer, 4-slave DUT for decode errors)
module tb_ahb2apb_bridge;
  import ahb2apb_bridge_pkg::*;
  typedef struct packed {
    logic [7:0]  psel;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] hrdata;
    logic        hresp;
    logic [7:0]  lows;
    logic [7:0]  acc;
    logic        stable;
  } xfer_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int waits_cfg = 0;
  int wait_left = 0;
  logic [31:0] last_rd = '0;
  logic [31:0] last_wd = '0;
  xfer_t exp_q[$];
  xfer_t obs_q[$];
  xfer_t cur = '0;
  logic pend = 1'b0;
  ahb2apb_bridge_if #(.SLV_NUM(8)) if8 ();
  ahb2apb_bridge_if #(.SLV_NUM(4)) if4 ();
  always #5 clk = ~clk;
  assign if8.hready = if8.hreadyout;
  assign if4.hready = if4.hreadyout;
  assign if8.pready = wait_left == 0;
  assign if4.hsel = if8.hsel;
  assign if4.haddr = if8.haddr;
  assign if4.htrans = if8.htrans;
  assign if4.hwrite = if8.hwrite;
  assign if4.hsize = if8.hsize;
  assign if4.hwdata = if8.hwdata;
  assign if4.prdata = if8.prdata;
  assign if4.pready = if8.pready;
  ahb2apb_bridge #(.SLV_NUM(8), .SEL_LSB(12)) u_dut (.hclk_i(clk), .hresetn_i(rst_n), .bus(if8.slave));
  ahb2apb_bridge #(.SLV_NUM(4), .SEL_LSB(12)) u_dut4 (.hclk_i(clk), .hresetn_i(rst_n), .bus(if4.slave));
  always @(posedge clk) wait_left <= !if8.penable ? waits_cfg : (wait_left != 0 ? wait_left - 1 : 0);
  always @(negedge clk) begin
    xfer_t n;
    logic p;
    n = cur;
    p = pend;
    if (!rst_n) p = 1'b0;
    else begin
      if (p) begin
        if (if8.psel != 0 && !if8.penable) {n.psel, n.paddr, n.pwrite, n.pwdata} = {if8.psel, if8.paddr, if8.pwrite, if8.pwdata};
        if (if8.penable) begin
          n.acc = n.acc + 8'd1;
          if ({if8.psel, if8.paddr, if8.pwrite, if8.pwdata} !== {n.psel, n.paddr, n.pwrite, n.pwdata}) n.stable = 1'b0;
        end
        if (!if8.hreadyout) n.lows = n.lows + 8'd1;
        else begin
          if (if8.psel != 0 || if8.penable) n.stable = 1'b0;
          n.hrdata = if8.hrdata;
          n.hresp = if8.hresp;
          obs_q.push_back(n);
          p = 1'b0;
        end
      end
      if (if8.hsel && if8.hready && if8.htrans[1]) begin
        p = 1'b1;
        n = '0;
        n.stable = 1'b1;
      end
    end
    cur <= n;
    pend <= p;
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drive(input bit wr, input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata, input int waits, input bit seq);
    xfer_t e;
    if8.hsel = 1'b1;
    if8.htrans = seq ? HTRANS_SEQ : HTRANS_NONSEQ;
    if8.haddr = addr;
    if8.hwrite = wr;
    if8.hsize = 3'b010;
    if8.prdata = rdata;
    waits_cfg = waits;
    if (wr) last_wd = wdata;
    else last_rd = rdata;
    e = '0;
    e.psel = 8'h1 << addr[14:12];
    e.paddr = addr;
    e.pwrite = wr;
    e.pwdata = last_wd;
    e.hrdata = last_rd;
    e.hresp = HRESP_OKAY;
    e.lows = 8'((wr ? 3 : 2) + waits);
    e.acc = 8'(1 + waits);
    e.stable = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if8.hsel = 1'b0;
    if8.htrans = HTRANS_IDLE;
    if8.hwdata = wdata;
  endtask
  task automatic wait_ready();
    for (int i = 0; i < 50 && !if8.hreadyout; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic get_obs(output bit ok, output xfer_t o, output xfer_t e);
    for (int i = 0; i < 60 && obs_q.size() == 0; i++) @(negedge clk);
    ok = obs_q.size() != 0 && exp_q.size() != 0;
    o = '0;
    e = '0;
    if (ok) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
    end
  endtask
  task automatic test_reset();
    step(3);
    tests++;
    if ({if8.hreadyout, if8.hresp, if8.hrdata} !== {1'b1, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL reset_ahb got rdy=%b resp=%b hrdata=%h want 1 0 0", if8.hreadyout, if8.hresp, if8.hrdata);
    end
    tests++;
    if ({if8.psel, if8.penable, if8.paddr, if8.pwrite, if8.pwdata} !== {8'h0, 1'b0, 32'h0, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL reset_apb got psel=%h en=%b paddr=%h pwrite=%b pwdata=%h want all 0", if8.psel, if8.penable, if8.paddr, if8.pwrite, if8.pwdata);
    end
    tests++;
    if ({if4.hreadyout, if4.hresp, if4.psel} !== {1'b1, 1'b0, 4'h0}) begin
      fails++;
      $display("FAIL reset_dut4 got rdy=%b resp=%b psel=%h want 1 0 0", if4.hreadyout, if4.hresp, if4.psel);
    end
    rst_n = 1'b1;
    step(1);
  endtask
  task automatic test_idle_busy();
    if8.hsel = 1'b1;
    if8.htrans = HTRANS_BUSY;
    if8.haddr = 32'h0000_1000;
    if8.hwrite = 1'b0;
    @(negedge clk);
    tests++;
    if ({if8.hreadyout, if8.hresp} !== {1'b1, HRESP_OKAY}) begin
      fails++;
      $display("FAIL busy_resp got rdy=%b resp=%b want 1 0", if8.hreadyout, if8.hresp);
    end
    step(1);
    if8.htrans = HTRANS_IDLE;
    @(negedge clk);
    tests++;
    if ({if8.hreadyout, if8.hresp, if8.psel, pend} !== {1'b1, 1'b0, 8'h0, 1'b0}) begin
      fails++;
      $display("FAIL idle_noxfer got rdy=%b resp=%b psel=%h pend=%b want 1 0 00 0", if8.hreadyout, if8.hresp, if8.psel, pend);
    end
    if8.hsel = 1'b0;
    step(1);
  endtask
  task automatic test_read0();
    bit ok;
    xfer_t o, e;
    drive(1'b0, 32'h0000_0004, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    get_obs(ok, o, e);
    tests++;
    if (!ok || o !== e) begin
      fails++;
      $display("FAIL read0 got %h want %h ok=%b", o, e, ok);
    end
    step(1);
  endtask
  task automatic test_write2();
    bit ok;
    xfer_t o, e;
    drive(1'b1, 32'h0000_2010, 32'h1234_5678, 32'h0, 0, 1'b0);
    get_obs(ok, o, e);
    tests++;
    if (!ok || o !== e) begin
      fails++;
      $display("FAIL write2 got %h want %h ok=%b", o, e, ok);
    end
    step(3);
    tests++;
    if ({if8.paddr, if8.pwrite, if8.pwdata, if8.psel, if8.penable, if8.hrdata} !== {32'h2010, 1'b1, 32'h1234_5678, 8'h0, 1'b0, 32'hDEAD_BEEF}) begin
      fails++;
      $display("FAIL idle_hold got paddr=%h pwrite=%b pwdata=%h psel=%h en=%b hrdata=%h", if8.paddr, if8.pwrite, if8.pwdata, if8.psel, if8.penable, if8.hrdata);
    end
  endtask
  task automatic test_wait_states();
    bit ok;
    xfer_t o, e;
    drive(1'b0, 32'h0000_7008, 32'h0, 32'h7777_0003, 3, 1'b0);
    get_obs(ok, o, e);
    tests++;
    if (!ok || o !== e) begin
      fails++;
      $display("FAIL wait3 got %h want %h ok=%b", o, e, ok);
    end
    step(1);
  endtask
  task automatic test_decode_error();
    bit ok;
    xfer_t o, e;
    drive(1'b0, 32'h0000_5000, 32'h0, 32'h0BAD_0005, 0, 1'b0);
    tests++;
    if ({if4.hresp, if4.hreadyout, if4.psel, if4.penable} !== {1'b1, 1'b0, 4'h0, 1'b0}) begin
      fails++;
      $display("FAIL err1 got resp=%b rdy=%b psel=%h en=%b want 1 0 0 0", if4.hresp, if4.hreadyout, if4.psel, if4.penable);
    end
    step(1);
    tests++;
    if ({if4.hresp, if4.hreadyout, if4.psel, if4.penable} !== {1'b1, 1'b1, 4'h0, 1'b0}) begin
      fails++;
      $display("FAIL err2 got resp=%b rdy=%b psel=%h en=%b want 1 1 0 0", if4.hresp, if4.hreadyout, if4.psel, if4.penable);
    end
    step(1);
    tests++;
    if ({if4.hresp, if4.hreadyout, if4.psel} !== {1'b0, 1'b1, 4'h0}) begin
      fails++;
      $display("FAIL err_end got resp=%b rdy=%b psel=%h want 0 1 0", if4.hresp, if4.hreadyout, if4.psel);
    end
    get_obs(ok, o, e);
    tests++;
    if (!ok || o !== e) begin
      fails++;
      $display("FAIL read5_dut8 got %h want %h ok=%b", o, e, ok);
    end
    step(2);
  endtask
  task automatic test_back_to_back();
    bit ok;
    xfer_t o, e;
    drive(1'b0, 32'h0000_1000, 32'h0, 32'hA5A5_0001, 0, 1'b0);
    wait_ready();
    drive(1'b1, 32'h0000_3000, 32'hCAFE_F00D, 32'h0, 0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      get_obs(ok, o, e);
      tests++;
      if (!ok || o !== e) begin
        fails++;
        $display("FAIL b2b_%0d got %h want %h ok=%b", k, o, e, ok);
      end
    end
    step(1);
  endtask
  task automatic test_random();
    bit ok;
    xfer_t o, e;
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 0) step(1);
      drive(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      wait_ready();
    end
    for (int k = 0; k < 8; k++) begin
      get_obs(ok, o, e);
      tests++;
      if (!ok || o !== e) begin
        fails++;
        $display("FAIL rand_%0d got %h want %h ok=%b", k, o, e, ok);
      end
    end
    step(2);
  endtask
  task automatic test_reset_mid_access();
    bit ok;
    xfer_t o, e;
    drive(1'b0, 32'h0000_1008, 32'h0, 32'h5555_AAAA, 10, 1'b0);
    step(1);
    tests++;
    if (if8.penable !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_access got penable=%b want 1", if8.penable);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({if8.psel, if8.penable, if8.hreadyout, if8.hresp} !== {8'h0, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_async got psel=%h en=%b rdy=%b resp=%b want 00 0 1 0", if8.psel, if8.penable, if8.hreadyout, if8.hresp);
    end
    tests++;
    if ({if8.hrdata, if8.pwdata, if8.paddr} !== 96'h0) begin
      fails++;
      $display("FAIL reset_regs got hrdata=%h pwdata=%h paddr=%h want 0", if8.hrdata, if8.pwdata, if8.paddr);
    end
    exp_q.delete();
    last_rd = '0;
    last_wd = '0;
    step(2);
    rst_n = 1'b1;
    step(1);
    drive(1'b0, 32'h0000_6020, 32'h0, 32'h6666_0006, 1, 1'b0);
    get_obs(ok, o, e);
    tests++;
    if (!ok || o !== e) begin
      fails++;
      $display("FAIL after_reset got %h want %h ok=%b", o, e, ok);
    end
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL aborted_xfer got %0d extra completions want 0", obs_q.size());
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end
  initial begin
    if8.hsel = 1'b0;
    if8.haddr = '0;
    if8.htrans = HTRANS_IDLE;
    if8.hwrite = 1'b0;
    if8.hsize = 3'b010;
    if8.hwdata = '0;
    if8.prdata = '0;
    test_reset();
    test_idle_busy();
    test_read0();
    test_write2();
    test_wait_states();
    test_decode_error();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
